// File: rtl/mips_multicycle.sv
// mips_multicycle -- multicycle MIPS subset core (lw, sw, add, sub, and, or,
// slt, beq, addi, j) with a single request/ready memory port shared by
// instruction fetch and data access. Undefined opcodes or functs park the
// core in TRAP until reset.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   mem_req    memory access request (FETCH, MEMREAD, MEMWRITE)
//   mem_we     1 = write, 0 = read; only meaningful while mem_req=1
//   mem_addr   byte address (low ADDR_W bits of the 32-bit address)
//   mem_wdata  store data
//   mem_rdata  read data, sampled in the cycle mem_ready=1
//   mem_ready  completes the pending access
//   pc         current program counter
//   Instr      instruction register
//   state      FSM state code
//   trap       high while in TRAP
module mips_multicycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       pc,
    output logic [31:0]       Instr,
    output logic [3:0]        state,
    output logic              trap
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    function automatic logic funct_ok_f(input logic [5:0] f);
        return (f == 6'h20) || (f == 6'h22) || (f == 6'h24) ||
               (f == 6'h25) || (f == 6'h2A);
    endfunction

    function automatic logic [2:0] alu_ctl_f(input logic [5:0] f);
        case (f)
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h22:   return 3'b110;
            6'h2A:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] ctl);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (ctl)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b110:  return a - b;
            3'b111:  return (sa < sb) ? 32'd1 : 32'd0;
            default: return a + b;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] aluout_q, aluout_d;
    logic [31:0] data_q, data_d;
    logic [31:0] rf_q [32];

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] addr_full;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] sign_imm, rs_val, rt_val;

    assign opcode   = instr_q[31:26];
    assign rs       = instr_q[25:21];
    assign rt       = instr_q[20:16];
    assign rd       = instr_q[15:11];
    assign funct    = instr_q[5:0];
    assign sign_imm = {{16{instr_q[15]}}, instr_q[15:0]};
    // $0 is hardwired: never read from storage
    assign rs_val   = (rs == 5'd0) ? 32'd0 : rf_q[rs];
    assign rt_val   = (rt == 5'd0) ? 32'd0 : rf_q[rt];

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        a_d      = a_q;
        b_d      = b_q;
        aluout_d = aluout_q;
        data_d   = data_q;
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    instr_d = mem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d      = rs_val;
                b_d      = rt_val;
                // branch target parked in ALUOut; pc is already pc+4 here
                aluout_d = pc_q + (sign_imm << 2);
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = funct_ok_f(funct) ? S_EXECUTE : S_TRAP;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                aluout_d = a_q + sign_imm;
                state_d  = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                if (mem_ready) begin
                    data_d  = mem_rdata;
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                rf_we    = 1'b1;
                rf_waddr = rt;
                rf_wdata = data_q;
                state_d  = S_FETCH;
            end
            S_MEMWRITE: begin
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTE: begin
                aluout_d = alu_f(a_q, b_q, alu_ctl_f(funct));
                state_d  = S_ALUWB;
            end
            S_ALUWB: begin
                rf_we    = 1'b1;
                rf_waddr = rd;
                rf_wdata = aluout_q;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                if (a_q == b_q) pc_d = aluout_q;
                state_d = S_FETCH;
            end
            S_ADDIEXEC: begin
                aluout_d = a_q + sign_imm;
                state_d  = S_ADDIWB;
            end
            S_ADDIWB: begin
                rf_we    = 1'b1;
                rf_waddr = rt;
                rf_wdata = aluout_q;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                pc_d    = {pc_q[31:28], instr_q[25:0], 2'b00};
                state_d = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            instr_q  <= 32'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            aluout_q <= 32'd0;
            data_q   <= 32'd0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
            data_q   <= data_d;
        end
    end

    // Register file is deliberately not cleared by reset; reset only blocks
    // an in-flight writeback.
    always_ff @(posedge clk) begin
        if (!reset && rf_we && (rf_waddr != 5'd0)) rf_q[rf_waddr] <= rf_wdata;
    end

    // While reset is held the port already looks like FETCH at RESET_PC, so a
    // store caught mid-access is never presented as a write.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_full = aluout_q;
        if (reset) begin
            mem_req   = 1'b1;
            addr_full = RESET_PC;
        end else begin
            case (state_q)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    addr_full = pc_q;
                end
                S_MEMREAD:  mem_req = 1'b1;
                S_MEMWRITE: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                end
                default: mem_req = 1'b0;
            endcase
        end
    end

    assign mem_addr  = addr_full[ADDR_W-1:0];
    assign mem_wdata = b_q;
    assign pc        = pc_q;
    assign Instr     = instr_q;
    assign state     = state_q;
    assign trap      = (state_q == S_TRAP);

endmodule
